// File: rtl/stem_pkg.sv
`default_nettype none
// Shared widths, frame defaults and FSM encoding for the stem window requester.
package stem_pkg;

  localparam int A_BITS    = 8;
  localparam int WIN_ELEMS = 27;
  localparam int WIN_W     = WIN_ELEMS * A_BITS;
  localparam int OUT_W     = 112;
  localparam int OUT_H     = 112;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_GAP   = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/win_fifo.sv
`default_nettype none
// First-word-fall-through register FIFO with occupancy count and synchronous flush.
module win_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  import stem_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/stem_window_requester.sv
`default_nettype none
// Pull-side requester: starts a fetcher frame, issues credit-limited window
// requests and re-streams the returned windows with coordinates and a last flag.
module stem_window_requester #(
  parameter int A_BITS     = stem_pkg::A_BITS,
  parameter int OUT_W      = stem_pkg::OUT_W,
  parameter int OUT_H      = stem_pkg::OUT_H,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 run,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_sync,
  output logic                                 err_timeout,
  output logic                                 start_frame,
  output logic                                 win_req,
  input  logic                                 win_valid,
  input  logic [stem_pkg::WIN_ELEMS*A_BITS-1:0] win_flat,
  input  logic [15:0]                          win_x,
  input  logic [15:0]                          win_y,
  input  logic                                 frame_done_in,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [stem_pkg::WIN_ELEMS*A_BITS-1:0] m_data,
  output logic [15:0]                          m_x,
  output logic [15:0]                          m_y,
  output logic                                 m_last
);
  import stem_pkg::*;

  localparam int DATA_W = WIN_ELEMS * A_BITS;
  localparam int ENT_W  = DATA_W + 33;
  localparam int N_WIN  = OUT_W * OUT_H;
  localparam int CNT_W  = $clog2(N_WIN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int FC_W   = $clog2(FIFO_DEPTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_sync_q, err_sync_d;
  logic             err_timeout_q, err_timeout_d;
  logic             done_q, done_d;

  logic             fifo_push, fifo_flush, fifo_pop;
  logic [ENT_W-1:0] fifo_head;
  logic [FC_W-1:0]  fifo_count;
  logic             rx_last;

  assign rx_last  = (rx_cnt_q == CNT_W'(N_WIN - 1));
  assign m_valid  = (fifo_count != '0);
  assign fifo_pop = m_valid && m_ready;

  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    err_sync_d    = err_sync_q;
    err_timeout_d = err_timeout_q;
    done_d        = 1'b0;
    start_frame   = 1'b0;
    win_req       = 1'b0;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d       = S_START;
          req_cnt_d     = '0;
          rx_cnt_d      = '0;
          err_sync_d    = 1'b0;
          err_timeout_d = 1'b0;
        end
      end
      S_START: begin
        start_frame = 1'b1;
        state_d     = S_GAP;
      end
      S_GAP: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // A request is only a credit if its window is sure to find a FIFO slot.
        if (fifo_count < FC_W'(FIFO_DEPTH)) begin
          win_req   = 1'b1;
          req_cnt_d = req_cnt_q + CNT_W'(1);
          tmo_cnt_d = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (win_valid) begin
          fifo_push = 1'b1;
          rx_cnt_d  = rx_cnt_q + CNT_W'(1);
          if (frame_done_in != rx_last) begin
            err_sync_d = 1'b1;
          end
          state_d = rx_last ? S_DRAIN : S_REQ;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          fifo_flush    = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_DRAIN: begin
        if (fifo_pop && m_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (win_valid && (state_q != S_WAIT)) begin
      err_sync_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_IDLE;
      req_cnt_q     <= '0;
      rx_cnt_q      <= '0;
      tmo_cnt_q     <= '0;
      err_sync_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_cnt_q     <= req_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      err_sync_q    <= err_sync_d;
      err_timeout_q <= err_timeout_d;
      done_q        <= done_d;
    end
  end

  win_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_win_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({win_flat, win_x, win_y, rx_last}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign m_data      = fifo_head[ENT_W-1 -: DATA_W];
  assign m_x         = fifo_head[32:17];
  assign m_y         = fifo_head[16:1];
  assign m_last      = fifo_head[0];
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_sync    = err_sync_q;
  assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_stem_window_requester.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized bench for stem_window_requester with a behavioural fixed-latency fetcher.
module tb_stem_window_requester;

  localparam int A_BITS     = 8;
  localparam int OUT_W      = 2;
  localparam int OUT_H      = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int TIMEOUT    = 64;
  localparam int LAT        = 21;
  localparam int N          = OUT_W * OUT_H;
  localparam int DW         = 27 * A_BITS;
  localparam int M_NORMAL   = 0;
  localparam int M_SYNC     = 1;
  localparam int M_SILENT   = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          run = 1'b0;
  logic          m_ready = 1'b1;
  logic          busy, done, err_sync, err_timeout, start_frame, win_req;
  logic          win_valid, frame_done_in;
  logic [DW-1:0] win_flat;
  logic [15:0]   win_x, win_y;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [15:0]   m_x, m_y;

  always #5 CLK = ~CLK;

  stem_window_requester #(
    .A_BITS     (A_BITS),
    .OUT_W      (OUT_W),
    .OUT_H      (OUT_H),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .run           (run),
    .busy          (busy),
    .done          (done),
    .err_sync      (err_sync),
    .err_timeout   (err_timeout),
    .start_frame   (start_frame),
    .win_req       (win_req),
    .win_valid     (win_valid),
    .win_flat      (win_flat),
    .win_x         (win_x),
    .win_y         (win_y),
    .frame_done_in (frame_done_in),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_x           (m_x),
    .m_y           (m_y),
    .m_last        (m_last)
  );

  // Behavioural fetcher: arms on start_frame, answers one request after LAT edges.
  int            fmode = M_NORMAL;
  logic          armed, pending;
  int            lat_cnt, idx;
  int            n_emit = 0;
  int            n_overlap = 0;
  logic [DW-1:0] rnd_q;
  logic [DW-1:0] sent [N];

  function automatic logic [DW-1:0] rand_win();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) begin
      v = {v[DW-33:0], 32'($urandom)};
    end
    return v;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      win_valid     <= 1'b0;
      frame_done_in <= 1'b0;
      win_flat      <= '0;
      win_x         <= '0;
      win_y         <= '0;
      armed         <= 1'b0;
      pending       <= 1'b0;
      lat_cnt       <= 0;
      idx           <= 0;
    end else begin
      rnd_q         <= rand_win();
      win_valid     <= 1'b0;
      frame_done_in <= 1'b0;
      if (win_req && pending) n_overlap <= n_overlap + 1;
      if (start_frame) begin
        armed   <= 1'b1;
        pending <= 1'b0;
        idx     <= 0;
      end else if (pending) begin
        if (fmode != M_SILENT) begin
          if (lat_cnt <= 1) begin
            pending       <= 1'b0;
            win_valid     <= 1'b1;
            win_flat      <= rnd_q;
            win_x         <= 16'(1 + 2 * (idx % OUT_W));
            win_y         <= 16'(1 + 2 * (idx / OUT_W));
            frame_done_in <= (fmode == M_SYNC) ? (idx == 1) : (idx == N - 1);
            if (idx < N) sent[idx] <= rnd_q;
            idx           <= idx + 1;
            n_emit        <= n_emit + 1;
          end else begin
            lat_cnt <= lat_cnt - 1;
          end
        end
      end else if (win_req && armed) begin
        pending <= 1'b1;
        lat_cnt <= LAT;
      end
    end
  end

  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_start = 0;
  int   f_req = 0, f_hs = 0, f_done = 0;
  logic prev_last = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Stream scoreboard: the k-th handshake of a frame must carry the k-th fetched window.
  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        f_req = 0; f_hs = 0; f_done = 0; prev_last = 1'b0;
        continue;
      end
      if (done || prev_last) check("done_timing", 256'(done), 256'(prev_last));
      prev_last = 1'b0;
      if (done) f_done++;
      if (start_frame) begin
        n_start++; f_req = 0; f_hs = 0; f_done = 0;
      end
      if (win_req) f_req++;
      if (m_valid && m_ready) begin
        if (f_hs >= N) begin
          check("extra_handshake", 256'(f_hs), 256'(N - 1));
        end else begin
          check("m_data", 256'(m_data), 256'(sent[f_hs]));
          check("m_x", 256'(m_x), 256'(1 + 2 * (f_hs % OUT_W)));
          check("m_y", 256'(m_y), 256'(1 + 2 * (f_hs / OUT_W)));
          check("m_last", 256'(m_last), 256'(f_hs == N - 1));
        end
        prev_last = m_last;
        f_hs++;
      end
    end
  endtask

  task automatic check_idle_outputs();
    check("rst_busy", 256'(busy), 0);
    check("rst_done", 256'(done), 0);
    check("rst_err_sync", 256'(err_sync), 0);
    check("rst_err_timeout", 256'(err_timeout), 0);
    check("rst_start_frame", 256'(start_frame), 0);
    check("rst_win_req", 256'(win_req), 0);
    check("rst_m_valid", 256'(m_valid), 0);
    check("rst_m_last", 256'(m_last), 0);
    check("rst_m_x", 256'(m_x), 0);
    check("rst_m_y", 256'(m_y), 0);
    check("rst_m_data", 256'(m_data), 0);
  endtask

  // run sampled at edge t: start_frame in t+1, gap in t+2, first request in t+3.
  task automatic do_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    check("start_frame_t1", 256'(start_frame), 1);
    check("busy_after_run", 256'(busy), 1);
    check("err_sync_cleared", 256'(err_sync), 0);
    check("err_timeout_cleared", 256'(err_timeout), 0);
    tick();
    check("start_frame_one_cycle", 256'(start_frame), 0);
    check("gap_no_req", 256'(win_req), 0);
    tick();
    check("first_req_t3", 256'(win_req), 1);
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    int k;
    for (k = 0; k < bound; k++) begin
      tick();
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      if (f_done > 0 && !busy) break;
    end
    m_ready = 1'b1;
    if (k == bound) check("wait_done_bound", 0, 1);
  endtask

  task automatic wait_emits(input int cnt);
    int base;
    int k;
    base = n_emit;
    for (k = 0; k < 400; k++) begin
      if (n_emit - base >= cnt) break;
      tick();
    end
    if (k == 400) check("wait_emit_bound", 0, 1);
  endtask

  task automatic frame_checks(input bit exp_sync);
    check("frame_req_count", 256'(f_req), N);
    check("frame_handshakes", 256'(f_hs), N);
    check("frame_done_count", 256'(f_done), 1);
    check("frame_err_sync", 256'(err_sync), 256'(exp_sync));
    check("frame_err_timeout", 256'(err_timeout), 0);
    check("frame_busy_end", 256'(busy), 0);
    check("frame_fifo_empty", 256'(m_valid), 0);
    check("overlapping_req", 256'(n_overlap), 0);
  endtask

  task automatic stimulus();
    int k;
    int s0;
    #1 RESET = 1'b0;
    #2 check_idle_outputs();
    tick(); tick();
    RESET = 1'b1;
    tick();
    check("idle_no_start", 256'(n_start), 0);

    // Full frame with a ready sink.
    do_run();
    wait_done(600, 1'b0);
    frame_checks(1'b0);

    // Backpressure: two windows fill the FIFO and hold off the third request.
    m_ready = 1'b0;
    do_run();
    wait_emits(2);
    repeat (40) tick();
    check("bp_req_stalled", 256'(f_req), 2);
    check("bp_no_req_full", 256'(win_req), 0);
    check("bp_head_valid", 256'(m_valid), 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("bp_pop_count", 256'(f_hs), 1);
    check("bp_req_after_credit", 256'(win_req), 1);
    m_ready = 1'b1;
    wait_done(600, 1'b0);
    frame_checks(1'b0);

    // Sync error: frame_done_in arrives on the second window instead of the last.
    fmode = M_SYNC;
    do_run();
    wait_done(600, 1'b0);
    frame_checks(1'b1);
    fmode = M_NORMAL;

    // Timeout: the fetcher never answers the first request.
    fmode = M_SILENT;
    do_run();
    for (k = 1; k <= 200; k++) begin
      tick();
      if (!busy) break;
    end
    check("timeout_latency", 256'(k), 65);
    check("timeout_err", 256'(err_timeout), 1);
    check("timeout_busy", 256'(busy), 0);
    check("timeout_m_valid", 256'(m_valid), 0);
    repeat (3) tick();
    check("timeout_no_done", 256'(f_done), 0);
    fmode = M_NORMAL;
    do_run();
    wait_done(600, 1'b0);
    frame_checks(1'b0);

    // run pulsed mid-frame is ignored.
    s0 = n_start;
    do_run();
    repeat (10) tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_done(600, 1'b0);
    frame_checks(1'b0);
    check("busy_run_single_start", 256'(n_start - s0), 1);

    // Randomized sink readiness.
    for (int f = 0; f < 3; f++) begin
      do_run();
      wait_done(1200, 1'b1);
      frame_checks(1'b0);
    end

    // Reset in the middle of a frame with windows buffered.
    m_ready = 1'b0;
    do_run();
    wait_emits(2);
    repeat (5) tick();
    check("pre_reset_buffered", 256'(m_valid), 1);
    #3 RESET = 1'b0;
    #1 check_idle_outputs();
    s0 = n_start;
    tick(); tick();
    check("reset_no_start", 256'(n_start - s0), 0);
    RESET = 1'b1;
    m_ready = 1'b1;
    tick();
    do_run();
    wait_done(600, 1'b0);
    frame_checks(1'b0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #2000000;
        check("global_watchdog", 0, 1);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stem_window_requester.md
# stem_window_requester

Pull-side controller for the stem-convolution window fetcher. It starts a frame on the fetcher and issues single-cycle window requests under a credit limit. Each returned 27-byte window (cin-fastest, 3×3×3 int8) is buffered in a small FIFO and re-presented to the stem PE array as a valid/ready stream with coordinates and a last flag. It also checks that the fetcher's frame-done pulse lines up with the expected last window.

## Interface
- A_BITS, 8: bits per channel sample (signed).
- OUT_W, 112: output windows per row (IMG_W/STRIDE).
- OUT_H, 112: output window rows.
- FIFO_DEPTH, 4: window buffer entries, ≥2.
- TIMEOUT, 64: max cycles from win_req to win_valid.
- CLK  in  1  clock.
- RESET  in  1  reset RESET, asynchronous, active-low; clock CLK.
- run  in  1  pulse: start one frame; ignored while busy.
- busy  out  1  frame in progress.
- done  out  1  1-cycle pulse after last window handshake downstream.
- err_sync  out  1  sticky; frame_done_in mismatch. Cleared by accepted run.
- err_timeout  out  1  sticky; fetcher response timeout. Cleared by accepted run.
- start_frame  out  1  1-cycle pulse to fetcher.
- win_req  out  1  1-cycle request pulse to fetcher.
- win_valid  in  1  fetcher window strobe.
- win_flat  in  27*A_BITS  fetched window.
- win_x, win_y  in  16 each  fetcher center coordinates.
- frame_done_in  in  1  fetcher last-window pulse.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  27*A_BITS  window at FIFO head.
- m_x, m_y  out  16 each  coordinates at FIFO head.
- m_last  out  1  head is window OUT_W*OUT_H-1.

## Operation
- FSM states are S_IDLE, S_START, S_GAP, S_REQ, S_WAIT and S_DRAIN.
- S_IDLE → S_START on run. On that edge: clear req_cnt, rx_cnt, err_sync and err_timeout.
- S_START drives start_frame=1 for exactly one cycle, then → S_GAP.
- S_GAP is a mandatory idle cycle. The fetcher arms on the start_frame edge and ignores a win_req issued in the same cycle. → S_REQ.
- S_REQ issues win_req=1 for one cycle only if fifo_count < FIFO_DEPTH. Then req_cnt++ and → S_WAIT. Otherwise it stalls in S_REQ with win_req=0.
- At most one request is outstanding. win_req is never asserted in S_WAIT because the fetcher drops requests while it is busy.
- S_WAIT: on win_valid, push {win_flat, win_x, win_y, last = (rx_cnt == OUT_W*OUT_H-1)} and rx_cnt++.
  - If that was the last window → S_DRAIN, else → S_REQ.
- FIFO space is guaranteed on push by the credit check in S_REQ.
- Sync check: frame_done_in must be high in exactly the cycle of the last win_valid. Asserting it on any other win_valid, or its absence on the last one, sets err_sync. The frame still completes.
- A timeout counter runs in S_WAIT. Reaching TIMEOUT without win_valid sets err_timeout, flushes the FIFO, clears busy → S_IDLE. No done pulse is issued.
- S_DRAIN: on the m_valid & m_ready handshake with m_last=1, pulse done next cycle → S_IDLE.
- busy=1 in every state except S_IDLE.
- FIFO is first-word-fall-through. m_valid = (fifo_count != 0). Head data stays stable while m_valid & !m_ready.
- A push and a pop in the same cycle leave fifo_count unchanged.
- Counter widths are $clog2(OUT_W*OUT_H+1). Pointers wrap modulo FIFO_DEPTH.
- Win_valid outside S_WAIT is dropped and sets err_sync.

## Timing
- Reset values: all outputs 0, FSM in S_IDLE, FIFO empty, counters 0.
- Reset mid-frame discards everything immediately. The fetcher shares RESET.
- run (edge t) → start_frame high in cycle t+1 → first win_req in cycle t+3.
- win_valid at edge t → m_valid high from t+1.
- Next win_req comes at the earliest one cycle after win_valid.
- Steady-state throughput is one window per (fetcher latency + 2) cycles when m_ready=1.
- done comes one cycle after the last handshake.

## Structure
- Shared package `stem_pkg`: A_BITS, WIN_ELEMS=27, WIN_W=27*A_BITS, OUT_W/OUT_H defaults, and the FSM state encoding.
- One sub-module, `win_fifo`: a parameterized FWFT register FIFO (width WIN_W+33, depth FIFO_DEPTH) with count output.

## Test plan
Bench uses OUT_W=2, OUT_H=2, FIFO_DEPTH=2, TIMEOUT=64, and a behavioural fetcher with 21-cycle latency.
- **Reset:** assert RESET low mid-sim → all outputs 0 within the cycle; state S_IDLE; no start_frame.
- **Full frame with m_ready=1:** run → one start_frame, exactly 4 win_req pulses, 4 handshakes with coordinates (1,1),(3,1),(1,3),(3,3), m_last only on the 4th. done one cycle later; err flags 0.
- **Backpressure:** m_ready=0 → after 2 windows fifo full, no 3rd win_req. Raising m_ready for one pop → the next win_req follows within 1 cycle of credit.
- **Sync error:** model asserts frame_done_in on window 2 → err_sync=1, all 4 windows still delivered, done pulses.
- **Timeout:** model never answers → err_timeout=1 after 64 cycles in S_WAIT, busy=0, m_valid=0, no done. A following run clears err_timeout.
- **Run while busy:** run pulsed mid-frame → ignored (req count still 4). RESET low mid-frame → FIFO empty and a new run restarts cleanly.
